perf_counter_bank: RTL

Parametrised memory-mapped performance-counter bank for the MIPS150 system, generalising the fixed cycle and instruction counters into NUM_CH independent event counters. Each channel has a configurable width, an enable, an optional stall gate, an atomic snapshot shadow, a sticky overflow flag and an interrupt. The block sits on the CPU's memory-mapped I/O decode next to the UART; its interrupt output feeds a CP0 interrupt line.

---
 rtl/perf_pkg.sv | 18 +
 rtl/perf_counter_chan.sv | 46 ++++
 rtl/perf_counter_bank.sv | 130 +++++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter bank:
// register offsets, CMD bit positions and parameter limits.
package perf_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_CNT_W = 32;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_CMD    = 8'h04;
    localparam logic [7:0] OFF_OVF    = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN = 8'h0C;
    localparam logic [7:0] SNAP_BASE  = 8'h40;
    localparam logic [7:0] LIVE_BASE  = 8'h80;

    localparam int CMD_CLEAR = 0;
    localparam int CMD_SNAP  = 1;

endpackage

// File: rtl/perf_counter_chan.sv
// One counter channel: live count, snapshot shadow, sticky overflow.
// In: inc/clear/snap/load/load_val/ovf_clr  Out: count/shadow/ovf
module perf_counter_chan #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    input  logic             snap,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);
    import perf_pkg::*;

    // An event only wraps when it is actually applied; clear and
    // preload both take priority and drop it.
    logic wrap;
    assign wrap = inc & ~clear & ~load & (&count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            if (snap)
                shadow <= count;
            if (clear)
                count <= '0;
            else if (load)
                count <= load_val;
            else if (inc)
                count <= count + 1'b1;
            if (wrap)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CH event counters with snapshot and irq.
// Bus: addr/we/wdata/re -> rdata/rvalid (1-cycle); evt/stall in; irq out.
module perf_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [NUM_CH-1:0] evt,
    input  logic [7:0]        addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              irq
);
    import perf_pkg::*;

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : gBadNumCh
        $error("perf_counter_bank: NUM_CH out of range");
    end
    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : gBadCntW
        $error("perf_counter_bank: CNT_W out of range");
    end

    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] stallGate;
    logic [NUM_CH-1:0] irqEn;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] ovfClr;
    logic [NUM_CH-1:0] chHit;
    logic [CNT_W-1:0]  liveCnt [NUM_CH];
    logic [CNT_W-1:0]  snapCnt [NUM_CH];

    logic [7:0]  wordAddr;
    logic        isCtrl, isCmd, isOvf, isIrqEn, isSnap, isLive;
    logic        clearCmd, snapCmd;
    logic [31:0] rdNext;
    logic        unusedBits;

    assign unusedBits = ^{addr[1:0], wdata};

    assign wordAddr = {addr[7:2], 2'b00};
    assign isCtrl   = wordAddr == OFF_CTRL;
    assign isCmd    = wordAddr == OFF_CMD;
    assign isOvf    = wordAddr == OFF_OVF;
    assign isIrqEn  = wordAddr == OFF_IRQ_EN;
    assign isSnap   = wordAddr[7:6] == SNAP_BASE[7:6];
    assign isLive   = wordAddr[7:6] == LIVE_BASE[7:6];

    // Channel index from addr[5:2]; indices >= NUM_CH never hit.
    always_comb begin
        chHit = '0;
        for (int i = 0; i < NUM_CH; i++)
            chHit[i] = int'(addr[5:2]) == i;
    end

    assign clearCmd = we & isCmd & wdata[CMD_CLEAR];
    assign snapCmd  = we & isCmd & wdata[CMD_SNAP];
    assign ovfClr   = (we & isOvf) ? wdata[NUM_CH-1:0] : '0;
    assign load     = (we & isLive) ? chHit : '0;
    assign inc      = enable & evt & ~(stallGate & {NUM_CH{stall}});
    assign irq      = |(ovf & irqEn);

    for (genvar i = 0; i < NUM_CH; i++) begin : gChan
        perf_counter_chan #(.CNT_W(CNT_W)) uChan (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[i]),
            .clear    (clearCmd),
            .snap     (snapCmd),
            .load     (load[i]),
            .load_val (wdata[CNT_W-1:0]),
            .ovf_clr  (ovfClr[i]),
            .count    (liveCnt[i]),
            .shadow   (snapCnt[i]),
            .ovf      (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable    <= '0;
            stallGate <= '0;
            irqEn     <= '0;
        end else begin
            if (we && isCtrl) begin
                enable    <= wdata[NUM_CH-1:0];
                stallGate <= wdata[16 +: NUM_CH];
            end
            if (we && isIrqEn)
                irqEn <= wdata[NUM_CH-1:0];
        end
    end

    always_comb begin
        rdNext = '0;
        unique case (1'b1)
            isCtrl:  rdNext = {16'(stallGate), 16'(enable)};
            isOvf:   rdNext = 32'(ovf);
            isIrqEn: rdNext = 32'(irqEn);
            isSnap: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (chHit[i]) rdNext = 32'(snapCnt[i]);
            end
            isLive: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (chHit[i]) rdNext = 32'(liveCnt[i]);
            end
            default: rdNext = '0;
        endcase
    end

    // rdata samples pre-write state, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re)
                rdata <= rdNext;
        end
    end

endmodule
